bcd_counter_chain: RTL and testbench
====================================

// Module: bcd_counter_chain
// PURPOSE
//   Parametrised multi-digit decade (BCD) counter. It is the successor to the single-digit 0-9 counter.
//   Adds cascaded digits, enable, up/down counting, synchronous load, terminal-count and a sticky overflow flag.
//   Used for event/time counting and for driving display logic that needs decimal digits.
// PARAMETERS
//   DIGITS  2  number of cascaded BCD digits (>=1); count range 0 .. 10^DIGITS-1
// PORTS
//   clk       in   1         rising-edge clock
//   reset     in   1         asynchronous, active-low reset (0 = reset asserted)
//   en        in   1         count enable; one step per clk edge while high
//   up        in   1         direction: 1 = increment, 0 = decrement
//   load      in   1         synchronous load of load_val
//   load_val  in   4*DIGITS  BCD value to load; digit k at [4k+3:4k]
//   out       out  4*DIGITS  current count, BCD, digit 0 = least significant
//   tc        out  1         terminal count (combinational): next enabled step wraps
//   ovf       out  1         sticky wrap flag (registered)
// BEHAVIOUR
//   Reset (reset==0, async, independent of clk): out=0, ovf=0.
//   - tc reads 0 unless en=1 and down-count (out=0).
//   Priority per clk edge: load > en > hold.
//   load=1: out<=load_val and ovf<=0, regardless of en/up.
//   - Any loaded digit >9 (4'hA-4'hF) is stored as 0; other digits load unchanged.
//   en=1, load=0, up=1: digit0 +1.
//   - Digit k (k>0) steps when every lower digit ==9.
//   - A stepping digit at 9 wraps to 0.
//   en=1, load=0, up=0: digit0 -1.
//   - Digit k steps when every lower digit ==0.
//   - A stepping digit at 0 wraps to 9.
//   Full wrap: all-9 -> all-0 (up), all-0 -> all-9 (down).
//   - On that edge ovf<=1; ovf holds until load or reset.
//   tc = en & ~load & (up ? all digits==9 : all digits==0).
//   - Asserted in the cycle before the wrapping edge; zero-latency from inputs.
//   en=0 and load=0: out and ovf hold.
//   - up may change any cycle; it takes effect on the next edge.
//   Latency: out reflects load/step one clk edge after inputs are sampled.
//   Digits never hold values >9 in any reachable state.
//   Reset asserted mid-count clears out and ovf immediately; counting resumes from 0 on the first edge after release.
// STRUCTURE
//   Shared package:
//   - BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0 constants
//   - function is_bcd(digit) used by load sanitising and bench checkers
//   Sub-module bcd_digit (one per digit, generate loop):
//   - inputs: clk, reset, step, up, load, din
//   - outputs: q, at_max (q==9), at_min (q==0)
//   Top level:
//   - forms step[k] = en & AND of lower at_max (up) or at_min (down)
//   - derives tc and registers ovf
// TESTING
//   1 Reset: hold reset=0 two cycles, en=1 -> out=0x00, ovf=0, tc=0; release -> first edge gives 0x01.
//   2 Up run, DIGITS=2: en=1, up=1 for 100 edges from 0.
//     - out steps 00..99 in BCD, never hex A-F.
//     - tc=1 only at 99; next edge out=00, ovf=1.
//   3 Down wrap: load 0x01, then en=1, up=0.
//     - out 01 -> 00 (tc=1) -> 99, ovf=1.
//     - 0x10 -> 0x09 shows the borrow across digits.
//   4 Load priority: out=0x37, en=1, up=1, load=1, load_val=0x42 -> out=0x42 (not 0x38), ovf cleared.
//     - load_val=0x4C -> out=0x40.
//   5 Hold/direction: en=0 for 5 edges at 0x58 -> out stays 0x58.
//     - Toggle up each cycle with en=1: 0x58 -> 0x59 -> 0x58 -> 0x59.
//   6 Async reset mid-count: assert reset between edges at out=0x73.
//     - out=0x00 before the next clk edge; ovf=0.
//   Re-run 2 and 3 with DIGITS=1 and DIGITS=4 (wrap 9999 <-> 0000).

Source files
------------

// File: rtl/bcd_counter_chain_pkg.sv
// bcd_counter_chain_pkg: shared BCD digit width, limits and the is_bcd legality check
package bcd_counter_chain_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;
  function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
    return digit <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_counter_chain_digit.sv
// bcd_digit: one decade digit; ports clk, reset(async low), step, up, load, din -> q, at_max, at_min
module bcd_digit
  import bcd_counter_chain_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             up,
  input  logic             load,
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] q,
  output logic             at_max,
  output logic             at_min
);
  assign at_max = q == BCD_MAX;
  assign at_min = q == BCD_MIN;
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= BCD_MIN;
    else if (load) q <= is_bcd(din) ? din : BCD_MIN;
    else if (step) q <= up ? (at_max ? BCD_MIN : q + 1'b1) : (at_min ? BCD_MAX : q - 1'b1);
endmodule

// File: rtl/bcd_counter_chain.sv
// bcd_counter_chain: cascaded BCD up/down counter; ports clk, reset(async low), en, up, load, load_val -> out, tc, ovf
module bcd_counter_chain
  import bcd_counter_chain_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    up,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_val,
  output logic [BCD_W*DIGITS-1:0] out,
  output logic                    tc,
  output logic                    ovf
);
  logic [DIGITS-1:0] at_max, at_min, step;
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    localparam logic [DIGITS-1:0] LOW = DIGITS'((64'd1 << g) - 64'd1);
    assign step[g] = en & (up ? &(at_max | ~LOW) : &(at_min | ~LOW));
    bcd_digit u_dig (
      .clk   (clk),
      .reset (reset),
      .step  (step[g]),
      .up    (up),
      .load  (load),
      .din   (load_val[BCD_W*g +: BCD_W]),
      .q     (out[BCD_W*g +: BCD_W]),
      .at_max(at_max[g]),
      .at_min(at_min[g])
    );
  end
  assign tc = en & ~load & (up ? &at_max : &at_min);
  always_ff @(posedge clk or negedge reset)
    if (!reset) ovf <= 1'b0;
    else if (load) ovf <= 1'b0;
    else if (tc) ovf <= 1'b1;
endmodule

// File: tb/tb_bcd_counter_chain.sv
// tb_bcd_counter_chain: checks 1-, 2- and 4-digit counters against an integer reference model
module tb_bcd_counter_chain;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0, up = 1'b1, load = 1'b0;
  logic [15:0] lv = '0;
  logic [3:0] o1;
  logic [7:0] o2;
  logic [15:0] o4;
  logic [2:0] tcs, ovfs;
  int checks = 0, errors = 0;
  int m[3];
  bit mo[3];
  int nd[3] = '{1, 2, 4};
  int md[3] = '{10, 100, 10000};

  always #5 clk = ~clk;

  bcd_counter_chain #(.DIGITS(1)) u1 (.clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .out(o1), .tc(tcs[0]), .ovf(ovfs[0]));
  bcd_counter_chain #(.DIGITS(2)) u2 (.clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv[7:0]), .out(o2), .tc(tcs[1]), .ovf(ovfs[1]));
  bcd_counter_chain #(.DIGITS(4)) u4 (.clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(lv), .out(o4), .tc(tcs[2]), .ovf(ovfs[2]));

  function automatic logic [15:0] outv(input int i);
    return i == 0 ? {12'd0, o1} : i == 1 ? {8'd0, o2} : o4;
  endfunction

  function automatic logic [15:0] to_bcd(input int v, input int d);
    logic [15:0] r = '0;
    int x = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] v, input int d);
    int r = 0, w = 1;
    for (int k = 0; k < d; k++) begin
      r += (v[4*k +: 4] > 4'd9 ? 0 : int'(v[4*k +: 4])) * w;
      w *= 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input int i, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s D=%0d observed=%h expected=%h", tag, nd[i], obs, exp);
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < 3; i++) begin
      chk("out", i, outv(i), to_bcd(m[i], nd[i]));
      chk("ovf", i, {15'd0, ovfs[i]}, {15'd0, mo[i]});
    end
  endtask

  task automatic tick();
    #1;
    for (int i = 0; i < 3; i++) begin
      bit wrap = up ? m[i] == md[i] - 1 : m[i] == 0;
      chk("tc", i, {15'd0, tcs[i]}, {15'd0, en & ~load & wrap});
      if (!reset) begin m[i] = 0; mo[i] = 0; end
      else if (load) begin m[i] = from_load(lv, nd[i]); mo[i] = 0; end
      else if (en) begin
        if (wrap) mo[i] = 1;
        m[i] = (m[i] + (up ? 1 : md[i] - 1)) % md[i];
      end
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; lv = v; tick(); load = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin m[i] = 0; mo[i] = 0; end
    en = 1'b1; up = 1'b1;
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    do_load(16'h0000);
    repeat (100) tick();
    do_load(16'h9990);
    repeat (12) tick();
    do_load(16'h0001);
    up = 1'b0;
    repeat (3) tick();
    do_load(16'h0010);
    tick();
    up = 1'b1;
    do_load(16'h0037);
    do_load(16'h0042);
    do_load(16'h004C);
    do_load(16'h0058);
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    repeat (4) begin up = ~up; tick(); end
    do_load(16'h0073);
    #3 reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin m[i] = 0; mo[i] = 0; end
    check_state();
    #1 reset = 1'b1;
    up = 1'b1;
    tick();
    repeat (400) begin
      en = 1'($urandom_range(0, 3) != 0);
      up = 1'($urandom);
      load = 1'($urandom_range(0, 15) == 0);
      lv = 16'($urandom);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
